// File: rtl/fb_rect_writer.sv
// -----------------------------------------------------------------------------
// fb_rect_writer
//
// Write-side producer for the SDRAM frame buffer. After a command is accepted
// it sweeps a 2^FB_W_LOG2 x 2^FB_H_LOG2 RGB555 frame in raster order and pushes
// one 16-bit word per pixel into the SDRAM write FIFO. The frame holds a single
// filled rectangle (foreground colour) drawn over a background colour. This is
// the counterpart of the VGA read path: the VGA controller drains the read FIFO
// and this block fills the write FIFO.
//
// Parameters
//   FB_W_LOG2      log2 of the frame width  (x counter width)
//   FB_H_LOG2      log2 of the frame height (y counter width)
//   SYNC_TO_FRAME  1: wait for iSOF before the first write
//                  0: start writing right after the command
//
// Optional feature
//   FBW_CHECKER_EN  when defined, the background becomes a 16x16 checkerboard
//                   of iBG_COLOR and ~iBG_COLOR (needs FB_W_LOG2, FB_H_LOG2 >= 5).
//                   When undefined the background is solid iBG_COLOR and no
//                   checker logic exists.
//
// Ports  (AW = FB_W_LOG2 + FB_H_LOG2)
//   iCLK        in   1            system clock
//   iRST_N      in   1            synchronous, active-low reset
//   iCMD_VALID  in   1            command request (taken when oCMD_READY is high)
//   oCMD_READY  out  1            high only while idle
//   iRECT_X0    in   FB_W_LOG2    rectangle left column
//   iRECT_Y0    in   FB_H_LOG2    rectangle top row
//   iRECT_W     in   FB_W_LOG2+1  rectangle width,  0..2^FB_W_LOG2
//   iRECT_H     in   FB_H_LOG2+1  rectangle height, 0..2^FB_H_LOG2
//   iFG_COLOR   in   15           rectangle colour {R5,G5,B5}
//   iBG_COLOR   in   15           background colour {R5,G5,B5}
//   iSOF        in   1            single-cycle VGA start-of-frame pulse
//   iFIFO_FULL  in   1            write FIFO (almost-)full, blocks writes
//   oWR         out  1            write strobe, one word per high cycle
//   oWR_DATA    out  16           {1'b0, R5, G5, B5}
//   oWR_ADDR    out  AW           pixel address {y, x}
//   oBUSY       out  1            high while waiting for SOF or filling
//   oDONE       out  1            one-cycle pulse after the last pixel write
// -----------------------------------------------------------------------------
module fb_rect_writer #(
    parameter int FB_W_LOG2     = 8,
    parameter int FB_H_LOG2     = 8,
    parameter bit SYNC_TO_FRAME = 1'b1
) (
    input  logic                             iCLK,
    input  logic                             iRST_N,
    input  logic                             iCMD_VALID,
    output logic                             oCMD_READY,
    input  logic [FB_W_LOG2-1:0]             iRECT_X0,
    input  logic [FB_H_LOG2-1:0]             iRECT_Y0,
    input  logic [FB_W_LOG2:0]               iRECT_W,
    input  logic [FB_H_LOG2:0]               iRECT_H,
    input  logic [14:0]                      iFG_COLOR,
    input  logic [14:0]                      iBG_COLOR,
    input  logic                             iSOF,
    input  logic                             iFIFO_FULL,
    output logic                             oWR,
    output logic [15:0]                      oWR_DATA,
    output logic [FB_W_LOG2+FB_H_LOG2-1:0]   oWR_ADDR,
    output logic                             oBUSY,
    output logic                             oDONE
);

    localparam int AW = FB_W_LOG2 + FB_H_LOG2;
    // Two spare bits so that X0+W and Y0+H never wrap; the rectangle is
    // clipped at the frame edge instead of reappearing at column/row 0.
    localparam int XW = FB_W_LOG2 + 2;
    localparam int YW = FB_H_LOG2 + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;

    // Command fields captured at accept time
    logic [FB_W_LOG2-1:0]   x0_q, x0_d;
    logic [FB_H_LOG2-1:0]   y0_q, y0_d;
    logic [FB_W_LOG2:0]     w_q, w_d;
    logic [FB_H_LOG2:0]     h_q, h_d;
    logic [14:0]            fg_q, fg_d;
    logic [14:0]            bg_q, bg_d;

    // Raster pixel counter, {y, x}
    logic [AW-1:0]          cnt_q, cnt_d;

    // Registered outputs
    logic                   wr_q, wr_d;
    logic [15:0]            data_q, data_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic                   issue;
    logic                   lastIssue;

    logic [FB_W_LOG2-1:0]   pixX;
    logic [FB_H_LOG2-1:0]   pixY;
    logic [XW-1:0]          xExt, x0Ext, xEnd;
    logic [YW-1:0]          yExt, y0Ext, yEnd;
    logic                   inRect;
    logic [14:0]            bgPix;
    logic [14:0]            pixColor;

    assign accept    = (state_q == ST_IDLE) && iCMD_VALID;
    assign issue     = (state_q == ST_FILL) && !iFIFO_FULL;
    assign lastIssue = issue && (cnt_q == {AW{1'b1}});

    // Rectangle membership of the pixel currently addressed by the counter
    always_comb begin
        pixX   = cnt_q[FB_W_LOG2-1:0];
        pixY   = cnt_q[AW-1:FB_W_LOG2];
        xExt   = {2'b00, pixX};
        x0Ext  = {2'b00, x0_q};
        xEnd   = x0Ext + {1'b0, w_q};
        yExt   = {2'b00, pixY};
        y0Ext  = {2'b00, y0_q};
        yEnd   = y0Ext + {1'b0, h_q};
        inRect = (xExt >= x0Ext) && (xExt < xEnd) &&
                 (yExt >= y0Ext) && (yExt < yEnd);
    end

    // Background colour: solid by default, 16x16 checkerboard when enabled
`ifdef FBW_CHECKER_EN
    always_comb begin
        bgPix = (pixX[4] ^ pixY[4]) ? ~bg_q : bg_q;
    end
`else
    always_comb begin
        bgPix = bg_q;
    end
`endif

    assign pixColor = inRect ? fg_q : bgPix;

    // State register; reset also abandons any partial frame
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = SYNC_TO_FRAME ? ST_WAIT_SOF : ST_FILL;
                end
            end
            ST_WAIT_SOF: begin
                if (iSOF) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (lastIssue) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values. Status flags follow the state being
    // entered so that they are aligned with it; oDONE is taken from the
    // current DONE state so it lands one cycle after the last write.
    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        busy_d  = (state_d == ST_WAIT_SOF) || (state_d == ST_FILL);
        done_d  = (state_q == ST_DONE);
        ready_d = (state_d == ST_IDLE);

        if (accept) begin
            x0_d  = iRECT_X0;
            y0_d  = iRECT_Y0;
            w_d   = iRECT_W;
            h_d   = iRECT_H;
            fg_d  = iFG_COLOR;
            bg_d  = iBG_COLOR;
            cnt_d = '0;
        end

        // A blocked cycle leaves the counter alone, so no pixel is lost
        // or repeated under backpressure.
        if (issue) begin
            wr_d   = 1'b1;
            addr_d = cnt_q;
            data_d = {1'b0, pixColor};
            cnt_d  = cnt_q + AW'(1);
        end
    end

    // Datapath and output registers
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign oCMD_READY = ready_q;
    assign oWR        = wr_q;
    assign oWR_DATA   = data_q;
    assign oWR_ADDR   = addr_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule
